// File: rtl/wrr_chk_pkg.sv
// Shared helpers for the WRR grant checker.
// Vector helpers work on a 64-bit view; callers zero-extend.
package wrr_chk_pkg;

  localparam int ERR_CNT_W = 8;

  typedef struct packed {
    logic       ok;
    logic [5:0] idx;
  } oh_t;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++)
      c = c + 7'(v[i]);
    return c;
  endfunction

  function automatic oh_t onehot_idx(input logic [63:0] v);
    oh_t r;
    r.ok  = (popcount(v) == 7'd1);
    r.idx = '0;
    for (int i = 63; i >= 0; i--)
      if (v[i]) r.idx = 6'(i);
    return r;
  endfunction

endpackage

// File: rtl/wrr_starve_ctr.sv
// Per-requester wait counter with a single-cycle
// strobe on the cycle the wait reaches the limit.
module wrr_starve_ctr #(
  parameter int SW           = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_i,
  input  logic          gnt_i,
  output logic          hit,
  output logic [SW-1:0] wait_cnt
);

  logic inc;

  assign inc = req_i && !gnt_i;

  // Crossing, not level: fires once per wait episode
  always_comb begin
    hit = 1'b0;
    if (!clr && inc && wait_cnt == SW'(STARVE_LIMIT - 1))
      hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr)
      wait_cnt <= '0;
    else if (!inc)
      wait_cnt <= '0;
    else if (wait_cnt != '1)
      wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: rtl/wrr_grant_checker.sv
// Grant-protocol checker for the WRR arbiter:
// legality flags, starvation and grant counters.
module wrr_grant_checker
  import wrr_chk_pkg::*;
#(
  parameter int N            = 32,
  parameter int IDW          = $clog2(N),
  parameter int CW           = 16,
  parameter int SW           = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 gnt_vld,
  input  logic [N-1:0]         gnt_w,
  input  logic [IDW-1:0]       gnt_id,
  input  logic                 clr,
  input  logic [IDW-1:0]       rd_idx,
  output logic [CW-1:0]        rd_cnt,
  output logic [CW-1:0]        total_cnt,
  output logic                 err_onehot,
  output logic                 err_id,
  output logic                 err_noreq,
  output logic                 err_starve,
  output logic [IDW-1:0]       starve_id,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic          wipe;
  oh_t           oh;
  logic          bad_oh;
  logic          bad_id;
  logic          bad_noreq;
  logic          viol;
  logic [N-1:0]  hit;
  logic [IDW-1:0] first;
  logic [CW-1:0] cnt [N];

  assign wipe = rst || clr;

  assign oh = onehot_idx(64'(gnt_w));

  assign bad_oh    = gnt_vld && !oh.ok;
  assign bad_id    = gnt_vld && oh.ok &&
                     (6'(gnt_id) != oh.idx ||
                      32'(gnt_id) >= N);
  assign bad_noreq = gnt_vld && oh.ok &&
                     !(|(req & gnt_w));
  assign viol      = bad_oh || bad_id ||
                     bad_noreq || (|hit);

  for (genvar i = 0; i < N; i++) begin : g_wait
    wrr_starve_ctr #(
      .SW           (SW),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_ctr (
      .clk      (clk),
      .clr      (wipe),
      .req_i    (req[i]),
      .gnt_i    (gnt_vld && gnt_w[i]),
      .hit      (hit[i]),
      .wait_cnt ()
    );
  end

  // Lowest starving index wins
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--)
      if (hit[i]) first = IDW'(i);
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int k = 0; k < N; k++)
        cnt[k] <= '0;
      total_cnt  <= '0;
      rd_cnt     <= '0;
      err_onehot <= 1'b0;
      err_id     <= 1'b0;
      err_noreq  <= 1'b0;
      err_starve <= 1'b0;
      starve_id  <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (gnt_vld && oh.ok && gnt_w[k] &&
            cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
      if (gnt_vld && total_cnt != '1)
        total_cnt <= total_cnt + 1'b1;
      rd_cnt <= (32'(rd_idx) < N) ? cnt[rd_idx] : '0;
      err_onehot <= err_onehot || bad_oh;
      err_id     <= err_id || bad_id;
      err_noreq  <= err_noreq || bad_noreq;
      if (!err_starve && |hit)
        starve_id <= first;
      err_starve <= err_starve || (|hit);
      err_pulse  <= viol;
      if (viol && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wrr_grant_checker.sv
// Directed bench for wrr_grant_checker: default
// instance plus a CW=4 instance for saturation.
module tb_wrr_grant_checker;
  import wrr_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        gnt_vld;
  logic [31:0] gnt_w;
  logic [4:0]  gnt_id;
  logic        clr;
  logic [4:0]  rd_idx;

  logic [15:0] rd_cnt, total_cnt;
  logic        err_onehot, err_id, err_noreq;
  logic        err_starve, err_pulse;
  logic [4:0]  starve_id;
  logic [7:0]  err_cnt;

  logic [3:0]  s_rd_cnt, s_total_cnt;
  logic        s_onehot, s_id, s_noreq;
  logic        s_starve, s_pulse;
  logic [4:0]  s_starve_id;
  logic [7:0]  s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrr_grant_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_vld    (gnt_vld),
    .gnt_w      (gnt_w),
    .gnt_id     (gnt_id),
    .clr        (clr),
    .rd_idx     (rd_idx),
    .rd_cnt     (rd_cnt),
    .total_cnt  (total_cnt),
    .err_onehot (err_onehot),
    .err_id     (err_id),
    .err_noreq  (err_noreq),
    .err_starve (err_starve),
    .starve_id  (starve_id),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt)
  );

  wrr_grant_checker #(.N(32), .CW(4)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_vld    (gnt_vld),
    .gnt_w      (gnt_w),
    .gnt_id     (gnt_id),
    .clr        (clr),
    .rd_idx     (rd_idx),
    .rd_cnt     (s_rd_cnt),
    .total_cnt  (s_total_cnt),
    .err_onehot (s_onehot),
    .err_id     (s_id),
    .err_noreq  (s_noreq),
    .err_starve (s_starve),
    .starve_id  (s_starve_id),
    .err_pulse  (s_pulse),
    .err_cnt    (s_err_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    gnt_vld = 1'b0;
    gnt_w   = '0;
    gnt_id  = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd"},   64'(rd_cnt), 0);
    chk({tag, ".tot"},  64'(total_cnt), 0);
    chk({tag, ".oh"},   64'(err_onehot), 0);
    chk({tag, ".id"},   64'(err_id), 0);
    chk({tag, ".nrq"},  64'(err_noreq), 0);
    chk({tag, ".stv"},  64'(err_starve), 0);
    chk({tag, ".sid"},  64'(starve_id), 0);
    chk({tag, ".pls"},  64'(err_pulse), 0);
    chk({tag, ".ecnt"}, 64'(err_cnt), 0);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    req = '0;
    rd_idx = '0;
    idle();
    step(2);
    rst = 1'b0;
    chk_zero("reset");

    // legal grant to 4
    req = 32'h10; rd_idx = 5'd4;
    gnt_vld = 1'b1; gnt_w = 32'h10; gnt_id = 5'd4;
    step();
    idle(); req = '0;
    chk("legal.oh",  64'(err_onehot), 0);
    chk("legal.id",  64'(err_id), 0);
    chk("legal.nrq", 64'(err_noreq), 0);
    chk("legal.pls", 64'(err_pulse), 0);
    chk("legal.tot", 64'(total_cnt), 1);
    chk("legal.rd0", 64'(rd_cnt), 0);
    step();
    chk("legal.rd1", 64'(rd_cnt), 1);
    chk("legal.ecnt", 64'(err_cnt), 0);

    // not one-hot
    do_clr();
    rd_idx = 5'd0; req = 32'h3;
    gnt_vld = 1'b1; gnt_w = 32'h3; gnt_id = 5'd0;
    step();
    idle(); req = '0;
    chk("noh.oh",   64'(err_onehot), 1);
    chk("noh.pls",  64'(err_pulse), 1);
    chk("noh.ecnt", 64'(err_cnt), 1);
    chk("noh.tot",  64'(total_cnt), 1);
    chk("noh.id",   64'(err_id), 0);
    chk("noh.nrq",  64'(err_noreq), 0);
    step();
    chk("noh.pls0", 64'(err_pulse), 0);
    chk("noh.oh1",  64'(err_onehot), 1);
    chk("noh.cnt0", 64'(rd_cnt), 0);
    rd_idx = 5'd1;
    step();
    chk("noh.cnt1", 64'(rd_cnt), 0);

    // ID mismatch and no request together
    do_clr();
    rd_idx = 5'd7; req = '0;
    gnt_vld = 1'b1; gnt_w = 32'h80; gnt_id = 5'd6;
    step();
    idle();
    chk("idnr.id",   64'(err_id), 1);
    chk("idnr.nrq",  64'(err_noreq), 1);
    chk("idnr.oh",   64'(err_onehot), 0);
    chk("idnr.pls",  64'(err_pulse), 1);
    chk("idnr.ecnt", 64'(err_cnt), 1);
    step();
    chk("idnr.pls0", 64'(err_pulse), 0);
    chk("idnr.ecnt1", 64'(err_cnt), 1);
    chk("idnr.cnt7", 64'(rd_cnt), 1);

    // simultaneous starvation of 3 and 9
    do_clr();
    req = 32'h208;
    step(63);
    chk("stv.pre",  64'(err_starve), 0);
    step();
    chk("stv.flag", 64'(err_starve), 1);
    chk("stv.sid",  64'(starve_id), 3);
    chk("stv.pls",  64'(err_pulse), 1);
    chk("stv.ecnt", 64'(err_cnt), 1);
    step();
    chk("stv.pls0", 64'(err_pulse), 0);
    gnt_vld = 1'b1; gnt_w = 32'h8; gnt_id = 5'd3;
    step();
    idle();
    step(70);
    chk("stv.flag2", 64'(err_starve), 1);
    chk("stv.sid2",  64'(starve_id), 3);
    chk("stv.ecnt2", 64'(err_cnt), 2);
    chk("stv.nrq",   64'(err_noreq), 0);
    req = '0;

    // counter saturation
    do_clr();
    req = 32'h4; rd_idx = 5'd2;
    gnt_vld = 1'b1; gnt_w = 32'h4; gnt_id = 5'd2;
    step(20);
    idle(); req = '0;
    step();
    chk("sat.rd",   64'(s_rd_cnt), 15);
    chk("sat.tot",  64'(s_total_cnt), 15);
    chk("sat.rdw",  64'(rd_cnt), 20);
    chk("sat.totw", 64'(total_cnt), 20);
    chk("sat.ecnt", 64'(s_err_cnt), 0);

    // clear colliding with an illegal grant
    clr = 1'b1;
    gnt_vld = 1'b1; gnt_w = '0; gnt_id = '0;
    step();
    clr = 1'b0;
    idle();
    chk_zero("clrcol");
    chk("clrcol.srd", 64'(s_rd_cnt), 0);
    step();
    chk("clrcol.pls", 64'(err_pulse), 0);
    chk("clrcol.oh",  64'(err_onehot), 0);

    // reset in the middle of a starvation wait
    req = 32'h8;
    step(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '0;
    chk_zero("rstmid");
    step(50);
    chk("rstmid.stv", 64'(err_starve), 0);
    chk("rstmid.ecnt", 64'(err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
